// File: rtl/hwag_wheel_gen.sv
// Crank trigger-wheel emulator: missing-tooth square wave (e.g. 60-2) from a programmable tooth period.
// Latency: all outputs registered; wheel_out/busy respond one edge after ena is sampled.
// Backpressure: none; free-running generator, period writes are shadowed and applied per position.
//
// Ports:
//   clk, rst            : clock and synchronous active-low reset
//   ena                 : level-sensitive generator enable
//   cfg_we, cfg_period  : shadow period write strobe and value (tooth period in clocks)
//   teeth_total/missing : N positions per revolution, M missing at the end (sampled at start)
//   wheel_out           : emulated crank signal
//   tooth_pos           : current wheel position 0..N-1
//   gap_start/rev_pulse : one-cycle pulses at position N-M and position 0
//   cfg_err, busy       : invalid configuration while enabled / generator running
module hwag_wheel_gen #(
    parameter int PW = 24,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_period,
    input  logic [TW-1:0] teeth_total,
    input  logic [TW-1:0] teeth_missing,
    output logic          wheel_out,
    output logic [TW-1:0] tooth_pos,
    output logic          gap_start,
    output logic          rev_pulse,
    output logic          cfg_err,
    output logic          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] shadow_q;
    logic [PW-1:0] per_q, per_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [TW-1:0] pos_q, pos_d;
    logic [TW-1:0] n_q, n_d;
    // First missing position (N-M); positions below it carry a real tooth.
    logic [TW-1:0] lim_q, lim_d;
    logic          wheel_d, gap_d, rev_d, err_d;
    logic          cfg_ok;
    logic          last_phase;
    logic [PW-1:0] shadow_clamped;

    // A period below 2 would leave no room for both a high and a low phase.
    assign shadow_clamped = (shadow_q < PW'(2)) ? PW'(2) : shadow_q;

    assign cfg_ok = (teeth_total >= TW'(2)) &&
                    (teeth_missing != '0) &&
                    (teeth_missing < teeth_total) &&
                    (shadow_q != '0);

    assign last_phase = (phase_q == per_q - PW'(1));

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        phase_d = phase_q;
        pos_d   = pos_q;
        n_d     = n_q;
        lim_d   = lim_q;
        gap_d   = 1'b0;
        rev_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                pos_d   = '0;
                if (ena) begin
                    if (cfg_ok) begin
                        // Initial start is not a revolution event: no rev_pulse here.
                        state_d = RUN;
                        per_d   = shadow_clamped;
                        n_d     = teeth_total;
                        lim_d   = teeth_total - teeth_missing;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!ena) begin
                    // Abandon any partial tooth immediately.
                    state_d = IDLE;
                    phase_d = '0;
                    pos_d   = '0;
                end else if (last_phase) begin
                    // Boundary copy reads the pre-write shadow, so a same-cycle
                    // cfg_we only takes effect from the following position.
                    phase_d = '0;
                    per_d   = shadow_clamped;
                    pos_d   = (pos_q == n_q - TW'(1)) ? '0 : pos_q + TW'(1);
                    rev_d   = (pos_d == '0);
                    gap_d   = (pos_d == lim_q);
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Output is computed from the next state so it can be registered with it.
        wheel_d = (state_d == RUN) && (pos_d < lim_d) && (phase_d < (per_d >> 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            per_q     <= '0;
            phase_q   <= '0;
            pos_q     <= '0;
            n_q       <= '0;
            lim_q     <= '0;
            wheel_out <= 1'b0;
            gap_start <= 1'b0;
            rev_pulse <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (cfg_we) begin
                shadow_q <= cfg_period;
            end
            state_q   <= state_d;
            per_q     <= per_d;
            phase_q   <= phase_d;
            pos_q     <= pos_d;
            n_q       <= n_d;
            lim_q     <= lim_d;
            wheel_out <= wheel_d;
            gap_start <= gap_d;
            rev_pulse <= rev_d;
            cfg_err   <= err_d;
        end
    end

    assign tooth_pos = pos_q;
    assign busy      = (state_q == RUN);

endmodule
